// File: rtl/posit_batch_pkg.sv
// Shared constants, FSM state encoding and the pair-count clamp helper
// for the posit batch sequencer.
package posit_batch_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 11;
    localparam int MAX_PAIRS = 1024;

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_B, WAIT_B, ISSUE, WAIT_RES, WRITE, DONE
    } state_t;

    // Operand pairs occupy two source words each, so at most half the RAM.
    function automatic logic [ADDR_W-1:0] clamp_count(input logic [ADDR_W-1:0] count);
        if (count > ADDR_W'(MAX_PAIRS)) begin
            return ADDR_W'(MAX_PAIRS);
        end
        return count;
    endfunction

endpackage

// File: rtl/posit_batch_sequencer_if.sv
// Control PIOs, both RAM second ports and the posit-unit handshake,
// bundled for the sequencer (master) and its environment (slave).
interface posit_batch_sequencer_if;
    import posit_batch_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] count;
    logic              busy;
    logic              completed;

    logic [ADDR_W-1:0] src_address;
    logic              src_chipselect;
    logic              src_clken;
    logic              src_write;
    logic [DATA_W-1:0] src_writedata;
    logic [1:0]        src_byteenable;
    logic [DATA_W-1:0] src_readdata;

    logic [ADDR_W-1:0] dst_address;
    logic              dst_chipselect;
    logic              dst_clken;
    logic              dst_write;
    logic [DATA_W-1:0] dst_writedata;
    logic [1:0]        dst_byteenable;
    logic [DATA_W-1:0] dst_readdata;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_num1;
    logic [DATA_W-1:0] op_num2;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    modport master (
        input  start, count, src_readdata, dst_readdata, op_ready, res_valid, res_data,
        output busy, completed,
               src_address, src_chipselect, src_clken, src_write, src_writedata, src_byteenable,
               dst_address, dst_chipselect, dst_clken, dst_write, dst_writedata, dst_byteenable,
               op_valid, op_num1, op_num2, res_ready
    );

    modport slave (
        output start, count, src_readdata, dst_readdata, op_ready, res_valid, res_data,
        input  busy, completed,
               src_address, src_chipselect, src_clken, src_write, src_writedata, src_byteenable,
               dst_address, dst_chipselect, dst_clken, dst_write, dst_writedata, dst_byteenable,
               op_valid, op_num1, op_num2, res_ready
    );

endinterface

// File: rtl/posit_batch_sequencer_rise_detect.sv
// Registered rising-edge detector; a level held high across reset
// produces an edge on the first clock after reset releases.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_reg;

    // Remember last cycle's level of the input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_reg <= 1'b0;
        end else begin
            d_reg <= d;
        end
    end

    assign rise = d & ~d_reg;

endmodule

// File: rtl/posit_batch_sequencer.sv
// Streams operand pairs from the source RAM through the posit unit into
// the destination RAM, one outstanding transaction at a time.
module posit_batch_sequencer
    import posit_batch_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    posit_batch_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE     = IDLE;
    localparam logic [2:0] S_RD_A     = RD_A;
    localparam logic [2:0] S_RD_B     = RD_B;
    localparam logic [2:0] S_WAIT_B   = WAIT_B;
    localparam logic [2:0] S_ISSUE    = ISSUE;
    localparam logic [2:0] S_WAIT_RES = WAIT_RES;
    localparam logic [2:0] S_WRITE    = WRITE;
    localparam logic [2:0] S_DONE     = DONE;

    logic [2:0]        state_reg;
    logic [2:0]        state_next;
    logic [ADDR_W-1:0] k_reg;
    logic [ADDR_W-1:0] total_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] r_reg;
    logic              completed_reg;

    logic              start_edge;
    logic              launch;
    logic              last_pair;
    logic [ADDR_W-1:0] total_launch;
    logic              unused_dst_readdata;

    rise_detect u_start_rise (
        .clock (clock),
        .reset (reset),
        .d     (bus.start),
        .rise  (start_edge)
    );

    // Start edges only count when no batch is running.
    assign launch       = start_edge & ((state_reg == S_IDLE) | (state_reg == S_DONE));
    assign total_launch = clamp_count(bus.count);
    assign last_pair    = (k_reg + ADDR_W'(1)) == total_reg;

    // The destination RAM is write-only from this side.
    assign unused_dst_readdata = ^bus.dst_readdata;

    // Next-state decode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (launch) begin
                    state_next = (total_launch == '0) ? S_DONE : S_RD_A;
                end else if (state_reg == S_DONE) begin
                    state_next = S_IDLE;
                end
            end
            S_RD_A:     state_next = S_RD_B;
            S_RD_B:     state_next = S_WAIT_B;
            S_WAIT_B:   state_next = S_ISSUE;
            S_ISSUE:    if (bus.op_ready) state_next = S_WAIT_RES;
            S_WAIT_RES: if (bus.res_valid) state_next = S_WRITE;
            S_WRITE:    state_next = last_pair ? S_DONE : S_RD_A;
            default:    state_next = S_IDLE;
        endcase
    end

    // State, pair index, batch length and the sticky completion flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            k_reg         <= '0;
            total_reg     <= '0;
            completed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (launch) begin
                total_reg     <= total_launch;
                k_reg         <= '0;
                // An empty batch completes immediately; otherwise clear the flag.
                completed_reg <= (total_launch == '0);
            end else if (state_reg == S_WRITE) begin
                if (last_pair) begin
                    completed_reg <= 1'b1;
                end else begin
                    k_reg <= k_reg + ADDR_W'(1);
                end
            end
        end
    end

    // Operand and result capture registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            r_reg <= '0;
        end else begin
            if (state_reg == S_RD_B) a_reg <= bus.src_readdata;
            if (state_reg == S_WAIT_B) b_reg <= bus.src_readdata;
            if ((state_reg == S_WAIT_RES) && bus.res_valid) r_reg <= bus.res_data;
        end
    end

    assign bus.busy      = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign bus.completed = completed_reg;

    // k never exceeds MAX_PAIRS-1, so doubling it fits ADDR_W bits without wrap.
    assign bus.src_address    = (state_reg == S_RD_A) ? {k_reg[ADDR_W-2:0], 1'b0} :
                                (state_reg == S_RD_B) ? {k_reg[ADDR_W-2:0], 1'b1} : '0;
    assign bus.src_chipselect = (state_reg == S_RD_A) || (state_reg == S_RD_B);
    assign bus.src_clken      = bus.src_chipselect;
    assign bus.src_write      = 1'b0;
    assign bus.src_writedata  = '0;
    assign bus.src_byteenable = 2'b11;

    assign bus.dst_address    = (state_reg == S_WRITE) ? k_reg : '0;
    assign bus.dst_writedata  = (state_reg == S_WRITE) ? r_reg : '0;
    assign bus.dst_chipselect = (state_reg == S_WRITE);
    assign bus.dst_clken      = (state_reg == S_WRITE);
    assign bus.dst_write      = (state_reg == S_WRITE);
    assign bus.dst_byteenable = 2'b11;

    assign bus.op_valid  = (state_reg == S_ISSUE);
    assign bus.op_num1   = (state_reg == S_ISSUE) ? a_reg : '0;
    assign bus.op_num2   = (state_reg == S_ISSUE) ? b_reg : '0;
    assign bus.res_ready = (state_reg == S_WAIT_RES);

endmodule

// File: tb/tb_posit_batch_sequencer.sv
// Bench for posit_batch_sequencer: RAM models, an adder stub for the posit
// unit with programmable stalls, and a write scoreboard.
module tb_posit_batch_sequencer;
    import posit_batch_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    posit_batch_sequencer_if bus ();

    posit_batch_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] src_mem [0:2047];
    logic [15:0] dst_mem [0:2047];
    logic [31:0] sb_q [$];

    int vectors     = 0;
    int miscompares = 0;
    int wr_count    = 0;
    int rd_count    = 0;
    int last_wr     = -1;
    int last_rd     = -1;
    int op_stall    = 0;
    int res_delay   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source RAM: one-cycle registered read.
    initial begin : src_ram
        logic        rd;
        logic [10:0] a;
        bus.src_readdata = '0;
        forever begin
            @(negedge clock);
            rd = bus.src_chipselect & bus.src_clken;
            a  = bus.src_address;
            if (rd) begin
                rd_count++;
                last_rd = int'(a);
                expect_eq("src_write_tie", {31'd0, bus.src_write}, 32'd0);
            end
            @(posedge clock);
            #1;
            if (rd && !reset) bus.src_readdata = src_mem[a];
        end
    end

    // Destination RAM plus scoreboard check on every write.
    initial begin : dst_ram
        logic [31:0] e;
        forever begin
            @(negedge clock);
            if (bus.dst_chipselect && bus.dst_clken && bus.dst_write) begin
                wr_count++;
                last_wr = int'(bus.dst_address);
                dst_mem[bus.dst_address] = bus.dst_writedata;
                $display("write addr=%0d data=%04h", bus.dst_address, bus.dst_writedata);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    expect_eq("wr_addr", {21'd0, bus.dst_address}, {16'd0, e[31:16]});
                    expect_eq("wr_data", {16'd0, bus.dst_writedata}, {16'd0, e[15:0]});
                end
            end
        end
    end

    // Posit-unit stub: result = num1 + num2, with programmable stalls.
    initial begin : stub
        logic        pend, prev_op_fire, prev_res_fire;
        logic [15:0] pend_res, prev_sum, held1, held2;
        int          op_wait, res_wait;
        pend = 0; prev_op_fire = 0; prev_res_fire = 0;
        pend_res = 0; prev_sum = 0; held1 = 0; held2 = 0;
        op_wait = 0; res_wait = 0;
        bus.op_ready = 0; bus.res_valid = 0; bus.res_data = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pend = 0; prev_op_fire = 0; prev_res_fire = 0; op_wait = 0; res_wait = 0;
                bus.op_ready = 0; bus.res_valid = 0; bus.res_data = 0;
            end else begin
                if (prev_op_fire) begin
                    pend = 1; pend_res = prev_sum; res_wait = 0; op_wait = 0;
                end
                if (prev_res_fire) pend = 0;
                if (bus.op_valid) begin
                    expect_eq("op_res_excl", {31'd0, bus.res_ready}, 32'd0);
                    if (op_wait == 0) begin
                        held1 = bus.op_num1;
                        held2 = bus.op_num2;
                    end else begin
                        expect_eq("num1_hold", {16'd0, bus.op_num1}, {16'd0, held1});
                        expect_eq("num2_hold", {16'd0, bus.op_num2}, {16'd0, held2});
                    end
                    bus.op_ready = (op_wait >= op_stall);
                    prev_sum = bus.op_num1 + bus.op_num2;
                    op_wait++;
                end else begin
                    bus.op_ready = 0;
                    op_wait = 0;
                end
                if (pend) begin
                    bus.res_valid = (res_wait >= res_delay);
                    bus.res_data  = bus.res_valid ? pend_res : 16'h0;
                    res_wait++;
                end else begin
                    bus.res_valid = 0;
                    bus.res_data  = 0;
                end
                prev_op_fire  = bus.op_valid & bus.op_ready;
                prev_res_fire = bus.res_valid & bus.res_ready;
            end
        end
    end

    // Run one batch; optionally re-pulse start mid-batch or reset during
    // the first WAIT_RES cycle of pair abort_pair.
    task automatic run_batch(input int cnt, input int pairs, input int retrig_at,
                             input int abort_pair, output bit aborted);
        int          n, busy_n, rr_seen, exp_n;
        bit          rr_prev, done;
        logic [15:0] s;
        wr_count = 0; rd_count = 0; last_wr = -1; last_rd = -1;
        for (int k = 0; k < pairs; k++) begin
            s = src_mem[2*k] + src_mem[2*k+1];
            sb_q.push_back({16'(k), s});
        end
        exp_n = 1 + pairs * (6 + op_stall + res_delay);
        bus.count = 11'(cnt);
        @(negedge clock);
        bus.start = 1'b1;
        n = 0; busy_n = 0; rr_seen = 0; rr_prev = 0; done = 0; aborted = 0;
        while (!done && n < exp_n + 50) begin
            @(negedge clock);
            n++;
            if (n == 3) bus.start = 1'b0;
            if (retrig_at > 0 && n == retrig_at) bus.start = 1'b1;
            if (bus.busy) busy_n++;
            if (bus.res_ready && !rr_prev) rr_seen++;
            rr_prev = bus.res_ready;
            if (abort_pair >= 0 && rr_seen == abort_pair + 1) begin
                #2;
                reset = 1'b1;
                #1;
                expect_eq("rst_busy",      {31'd0, bus.busy},           32'd0);
                expect_eq("rst_completed", {31'd0, bus.completed},      32'd0);
                expect_eq("rst_res_ready", {31'd0, bus.res_ready},      32'd0);
                expect_eq("rst_dst_write", {31'd0, bus.dst_write},      32'd0);
                expect_eq("rst_src_cs",    {31'd0, bus.src_chipselect}, 32'd0);
                expect_eq("rst_dst_be",    {30'd0, bus.dst_byteenable}, 32'd3);
                expect_eq("abort_writes",  wr_count, abort_pair);
                aborted = 1;
                bus.start = 1'b0;
                sb_q.delete();
                repeat (2) @(negedge clock);
                reset = 1'b0;
                @(negedge clock);
                return;
            end
            if (bus.completed) done = 1;
        end
        expect_eq("done_seen",   {31'd0, done}, 32'd1);
        expect_eq("cycles",      n, exp_n);
        expect_eq("busy_cycles", busy_n, exp_n - 1);
        expect_eq("writes",      wr_count, pairs);
        expect_eq("reads",       rd_count, 2 * pairs);
        expect_eq("sb_empty",    sb_q.size(), 0);
        $display("batch count=%0d pairs=%0d cycles=%0d writes=%0d", cnt, pairs, n, wr_count);
        bus.start = 1'b0;
        @(negedge clock);
    endtask

    initial begin : main
        bit ab;
        bus.start = 1'b0;
        bus.count = '0;
        bus.dst_readdata = '0;
        for (int i = 0; i < 2048; i++) begin
            src_mem[i] = '0;
            dst_mem[i] = '0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        expect_eq("rst_busy0",      {31'd0, bus.busy},           32'd0);
        expect_eq("rst_completed0", {31'd0, bus.completed},      32'd0);
        expect_eq("rst_op_valid0",  {31'd0, bus.op_valid},       32'd0);
        expect_eq("rst_src_cs0",    {31'd0, bus.src_chipselect}, 32'd0);
        expect_eq("rst_src_addr0",  {21'd0, bus.src_address},    32'd0);
        expect_eq("rst_src_be0",    {30'd0, bus.src_byteenable}, 32'd3);
        expect_eq("rst_dst_be0",    {30'd0, bus.dst_byteenable}, 32'd3);
        reset = 1'b0;
        @(negedge clock);

        // Single pair.
        src_mem[0] = 16'h4000;
        src_mem[1] = 16'h1000;
        run_batch(1, 1, 0, -1, ab);
        expect_eq("t1_dst0", {16'd0, dst_mem[0]}, 32'h5000);
        expect_eq("t1_completed", {31'd0, bus.completed}, 32'd1);

        // Four pairs, src[i] = i+1.
        for (int i = 0; i < 8; i++) src_mem[i] = 16'(i + 1);
        run_batch(4, 4, 0, -1, ab);
        expect_eq("t2_dst0", {16'd0, dst_mem[0]}, 32'h0003);
        expect_eq("t2_dst1", {16'd0, dst_mem[1]}, 32'h0007);
        expect_eq("t2_dst2", {16'd0, dst_mem[2]}, 32'h000B);
        expect_eq("t2_dst3", {16'd0, dst_mem[3]}, 32'h000F);
        expect_eq("t2_last_wr", last_wr, 3);

        // Backpressure on both handshakes.
        for (int i = 0; i < 6; i++) src_mem[i] = 16'($urandom);
        op_stall = 5;
        res_delay = 3;
        run_batch(3, 3, 0, -1, ab);
        op_stall = 0;
        res_delay = 0;

        // Empty batch.
        run_batch(0, 0, 0, -1, ab);
        expect_eq("t4_completed", {31'd0, bus.completed}, 32'd1);

        // Start re-pulsed mid-batch is ignored.
        for (int i = 0; i < 8; i++) src_mem[i] = 16'($urandom);
        run_batch(4, 4, 10, -1, ab);

        // Oversized count clamps to MAX_PAIRS.
        for (int i = 0; i < 2048; i++) src_mem[i] = 16'($urandom);
        run_batch(2047, 1024, 0, -1, ab);
        expect_eq("clamp_last_wr", last_wr, 1023);
        expect_eq("clamp_last_rd", last_rd, 2047);

        // Reset during WAIT_RES of the second pair, then a clean rerun.
        for (int i = 0; i < 8; i++) src_mem[i] = 16'(i + 1);
        for (int i = 0; i < 4; i++) dst_mem[i] = '0;
        run_batch(4, 4, 0, 1, ab);
        expect_eq("abort_hit", {31'd0, ab}, 32'd1);
        expect_eq("post_rst_completed", {31'd0, bus.completed}, 32'd0);
        run_batch(4, 4, 0, -1, ab);
        expect_eq("rerun_dst0", {16'd0, dst_mem[0]}, 32'h0003);
        expect_eq("rerun_dst1", {16'd0, dst_mem[1]}, 32'h0007);
        expect_eq("rerun_dst2", {16'd0, dst_mem[2]}, 32'h000B);
        expect_eq("rerun_dst3", {16'd0, dst_mem[3]}, 32'h000F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/posit_batch_sequencer.md
Name: posit_batch_sequencer

Overview:
- FPGA-fabric engine between the HPS system's two dual-port on-chip RAMs (second ports) and the posit arithmetic unit.
- When the start PIO rises, it streams operand pairs out of the source RAM (16-bit posit words at addresses 2k and 2k+1), hands each pair to the posit unit over a valid/ready handshake, and writes each 16-bit result to the destination RAM at address k.
- Signals completion back to the completed PIO.

Parameters:
- DATA_W, 16, posit word width and RAM data width.
- ADDR_W, 11, RAM word-address width (2048 words per RAM).
- MAX_PAIRS, 1024, largest pair count; 2^ADDR_W / 2.

Ports:
- clock  in  1  sole clock (pll_clk domain).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level from the start PIO; only its rising edge is used.
- count  in  ADDR_W  number of operand pairs; values above MAX_PAIRS are clamped to MAX_PAIRS.
- busy  out  1  high while a batch is in progress.
- completed  out  1  sticky done flag, feeds the completed PIO.
- src_address  out  ADDR_W  source RAM address.
- src_chipselect, src_clken  out  1  source RAM strobes.
- src_write  out  1  always 0.
- src_writedata  out  DATA_W  always 0.
- src_byteenable  out  2  always 2'b11.
- src_readdata  in  DATA_W  source RAM read data; valid 1 cycle after the address.
- dst_address  out  ADDR_W  destination RAM address.
- dst_chipselect, dst_clken, dst_write  out  1  destination RAM strobes.
- dst_writedata  out  DATA_W  result word.
- dst_byteenable  out  2  always 2'b11.
- dst_readdata  in  DATA_W  unused.
- op_valid  out  1  operand pair valid.
- op_ready  in  1  posit unit accepts the pair.
- op_num1, op_num2  out  DATA_W  operands.
- res_valid  in  1  result valid.
- res_ready  out  1  sequencer accepts the result.
- res_data  in  DATA_W  result word.

Behaviour:
- Reset: asynchronous, active-high, clock is the only clock. All outputs go to 0 except the tie-offs (byteenables = 2'b11). State = IDLE; k, captured operands, total and the start-edge register all clear.
- Start edge: start_q registers start. A rising edge is start & ~start_q.
  - Edges seen while busy are ignored.
  - An edge in IDLE or DONE clears completed in the same cycle, latches total = min(count, MAX_PAIRS), sets k = 0.
  - The FSM then goes to RD_A, or straight to DONE if total = 0.
- FSM states and transitions:
  - IDLE: busy = 0.
  - RD_A: src_address = 2k, src_chipselect = src_clken = 1. Next: RD_B.
  - RD_B: src_address = 2k+1, strobes = 1; capture A <= src_readdata. Next: WAIT_B.
  - WAIT_B: capture B <= src_readdata; strobes = 0. Next: ISSUE.
  - ISSUE: op_valid = 1, op_num1 = A, op_num2 = B, both held stable until op_ready. On op_valid & op_ready: Next WAIT_RES.
  - WAIT_RES: res_ready = 1. On res_valid, capture R <= res_data. Next: WRITE.
  - WRITE: dst_address = k, dst_writedata = R, dst_chipselect = dst_clken = dst_write = 1 for exactly one cycle. If k+1 = total, next is DONE; otherwise k <= k+1 and next is RD_A.
  - DONE: completed <= 1, busy = 0. Next: IDLE. completed stays high until the next start edge or reset.
- busy is 1 in RD_A through WRITE.
- Per-pair latency: 6 cycles minimum, i.e. with op_ready = 1 in ISSUE and res_valid = 1 on the first WAIT_RES cycle. Stalls on either handshake extend it by the stall length.
- Address arithmetic: k is ADDR_W bits wide; 2k+1 is at most 2047 and never wraps; last write address is total-1.
- The posit unit never sees op_valid and res_ready high in the same cycle: one transaction is outstanding at a time.
- Reset mid-batch: the batch is abandoned and completed = 0. RAM contents already written remain; the bench must not expect rollback.
- If start is held high across reset, start_q is 0 after reset, so the first clock sees an edge and a new batch begins.

Decomposition:
- Package posit_batch_pkg:
  - DATA_W, ADDR_W, MAX_PAIRS constants.
  - state enum {IDLE, RD_A, RD_B, WAIT_B, ISSUE, WAIT_RES, WRITE, DONE}.
  - Helper that clamps count.
- One sub-module, rise_detect: registered rising-edge detector with async active-high reset, used for start.
- Everything else stays flat in posit_batch_sequencer.

Test Plan:
- Single pair, stub unit (res = num1 + num2 mod 2^16, ready/valid always 1): src[0]=0x4000, src[1]=0x1000, count=1. Required: dst[0]=0x5000; completed rises 7 cycles after the start edge (edge cycle + 6 for the pair); busy high exactly during the pair.
- Batch of 4 pairs, src[i]=i+1: dst = {0x0003, 0x0007, 0x000B, 0x000F}; dst_write pulses exactly 4 times at addresses 0..3.
- Backpressure: op_ready low 5 cycles, res_valid delayed 3 cycles. Required: op_num1/op_num2 stable while op_valid is high; no duplicate write; per-pair latency = 6+8 cycles.
- Edge cases:
  - count=0: completed=1 with no RAM access.
  - count=2047: clamped to 1024, last write at dst address 1023, last read at src address 2047.
  - Second start edge during a batch: ignored, write count unchanged.
- Reset asserted in WAIT_RES of pair 2 of 4: all outputs return to reset values immediately; completed=0. A new start edge then reruns the batch from k=0 and produces correct dst[0..3].
